// File: rtl/hs_pkg.sv
// Shared HS-SCCH/AGCH constants: FSM encodings, mode codes, section lengths, code generators and CRC polynomial.
package hs_pkg;

  localparam int unsigned PAY_W  = 13;
  localparam int unsigned UEID_W = 16;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned SR_W   = 8;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SYM_W  = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned ST_W   = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PAY    = 3'd1;
  localparam logic [2:0] ST_CRC    = 3'd2;
  localparam logic [2:0] ST_TAIL   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [1:0] HS_PART1 = 2'b00;
  localparam logic [1:0] HS_PART2 = 2'b01;
  localparam logic [1:0] HS_AGCH  = 2'b10;
  localparam logic [1:0] HS_RSVD  = 2'b11;

  localparam logic [8:0]  G0       = 9'o557;
  localparam logic [8:0]  G1       = 9'o663;
  localparam logic [8:0]  G2       = 9'o711;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  localparam logic [4:0] LEN_PART1_PAY = 5'd8;
  localparam logic [4:0] LEN_PART2_PAY = 5'd13;
  localparam logic [4:0] LEN_AGCH_PAY  = 5'd6;
  localparam logic [4:0] LEN_CRC       = 5'd16;
  localparam logic [4:0] LEN_TAIL      = 5'd8;

  // Word context captured on start; mask already resolved to the selected UE identity.
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [PAY_W-1:0]  payload;
    logic [UEID_W-1:0] mask;
  } hs_word_t;

  function automatic logic [4:0] pay_len(input logic [1:0] mode);
    case (mode)
      HS_PART2: return LEN_PART2_PAY;
      HS_AGCH:  return LEN_AGCH_PAY;
      default:  return LEN_PART1_PAY;
    endcase
  endfunction

  function automatic logic has_crc(input logic [1:0] mode);
    return (mode != HS_PART1);
  endfunction

endpackage

// File: rtl/venc_hs_cc.sv
// Rate-1/3 K=9 convolutional encoder core: 8-bit shift register plus three generator parity trees.
module venc_hs_cc
  import hs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [SYM_W-1:0] sym_c_o
);

  logic [SR_W-1:0] sr_q, sr_d;
  logic [SR_W:0]   taps_c;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = {bit_i, sr_q[SR_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Generator MSB taps the current input bit, LSB the oldest stored bit.
  assign taps_c  = {bit_i, sr_q};
  assign sym_c_o = {^(G0 & taps_c), ^(G1 & taps_c), ^(G2 & taps_c)};

endmodule

// File: rtl/venc_hs_enc.sv
// HS-SCCH/AGCH control-word encoder: payload + UE-masked CRC-16 + 8 tail bits, rate-1/3 K=9 coded.
// Optional: VENC_HS_AGCH_SEC_EN adds ue_id_sec/id_sel to mask AGCH CRC with the secondary E-RNTI.
module venc_hs_enc
  import hs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] hs_mode,
  input  logic [PAY_W-1:0]  payload,
  input  logic [UEID_W-1:0] ue_id,
`ifdef VENC_HS_AGCH_SEC_EN
  input  logic [UEID_W-1:0] ue_id_sec,
  input  logic              id_sel,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic [ST_W-1:0]   fsm_out
);

  logic [ST_W-1:0]   state_q, state_d;
  hs_word_t          word_q, word_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [UEID_W-1:0] mask_sel_c;
  logic [3:0]        pay_idx_c;
  logic [3:0]        crc_idx_c;
  logic              bit_in_c;
  logic              beat_c;
  logic              sr_clr_c;
  logic [SYM_W-1:0]  sym_c;

`ifdef VENC_HS_AGCH_SEC_EN
  assign mask_sel_c = ((hs_mode == HS_AGCH) && id_sel) ? ue_id_sec : ue_id;
`else
  assign mask_sel_c = ue_id;
`endif

  assign out_valid = (state_q == ST_PAY) || (state_q == ST_CRC) || (state_q == ST_TAIL);
  assign beat_c    = out_valid & out_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign fsm_out   = state_q;
  assign out_data  = out_valid ? sym_c : '0;

  // Encoder input bit for the current section, derived from registers only.
  always_comb begin
    pay_idx_c = 4'(pay_len(word_q.mode) - 5'd1 - cnt_q);
    crc_idx_c = 4'(4'd15 - cnt_q[3:0]);
    bit_in_c  = 1'b0;
    case (state_q)
      ST_PAY:  bit_in_c = word_q.payload[pay_idx_c];
      ST_CRC:  bit_in_c = crc_q[CRC_W-1] ^ word_q.mask[crc_idx_c];
      default: bit_in_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    sr_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (hs_mode == HS_RSVD) begin
            state_d = ST_FINISH;
          end else begin
            word_d   = '{mode: hs_mode, payload: payload, mask: mask_sel_c};
            crc_d    = '0;
            cnt_d    = '0;
            sr_clr_c = 1'b1;
            state_d  = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (beat_c) begin
          crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ bit_in_c) ? CRC_POLY : '0);
          if (cnt_q == pay_len(word_q.mode) - 5'd1) begin
            cnt_d   = '0;
            state_d = has_crc(word_q.mode) ? ST_CRC : ST_TAIL;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_CRC: begin
        if (beat_c) begin
          crc_d = {crc_q[CRC_W-2:0], 1'b0};
          if (cnt_q == LEN_CRC - 5'd1) begin
            cnt_d   = '0;
            state_d = ST_TAIL;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_TAIL: begin
        if (beat_c) begin
          if (cnt_q == LEN_TAIL - 5'd1) begin
            cnt_d   = '0;
            state_d = ST_FINISH;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

  venc_hs_cc u_cc (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sr_clr_c),
    .en_i    (beat_c),
    .bit_i   (bit_in_c),
    .sym_c_o (sym_c)
  );

endmodule

// File: tb/tb_venc_hs_enc.sv
// Self-checking bench for venc_hs_enc: directed scenarios plus randomized words against a convolution-based model.
module tb_venc_hs_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  hs_mode;
  logic [12:0] payload;
  logic [15:0] ue_id;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_data;
  logic        busy;
  logic        done;
  logic [2:0]  fsm_out;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got[$];

  always #5 clk = ~clk;

  venc_hs_enc dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hs_mode   (hs_mode),
    .payload   (payload),
    .ue_id     (ue_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .fsm_out   (fsm_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: build the full bit string, then convolve it with the three generators.
  task automatic build_exp(input logic [1:0] mode, input logic [12:0] pl, input logic [15:0] id);
    int plen;
    int clen;
    logic bits[$];
    logic [15:0] crc;
    logic b;
    logic fb;
    logic acc;
    logic [2:0] sym;
    logic [8:0] gens[3];
    exp_q.delete();
    if (mode == 2'd3) return;
    plen = (mode == 2'd0) ? 8 : (mode == 2'd1) ? 13 : 6;
    clen = (mode == 2'd0) ? 0 : 16;
    crc = 16'h0000;
    for (int i = 0; i < plen; i++) begin
      b = pl[plen-1-i];
      bits.push_back(b);
      fb = crc[15] ^ b;
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    for (int i = 0; i < clen; i++) bits.push_back(crc[15-i] ^ id[15-i]);
    repeat (8) bits.push_back(1'b0);
    gens[0] = 9'o557;
    gens[1] = 9'o663;
    gens[2] = 9'o711;
    for (int j = 0; j < bits.size(); j++) begin
      for (int g = 0; g < 3; g++) begin
        acc = 1'b0;
        for (int k = 0; k <= 8; k++) begin
          if (j >= k) acc = acc ^ (gens[g][8-k] & bits[j-k]);
        end
        sym[2-g] = acc;
      end
      exp_q.push_back(sym);
    end
  endtask

  task automatic run_word(input logic [1:0] mode, input logic [12:0] pl, input logic [15:0] id,
                          input bit rand_rdy, input int stall_at, input int busy_start_at,
                          input bit finish_start, input int abort_at);
    int beats;
    int cyc;
    int stall_cnt;
    bit seen_done;
    bit holding;
    bit bs_done;
    bit rdy;
    logic [2:0] held;
    beats = 0; cyc = 0; stall_cnt = 0;
    seen_done = 0; holding = 0; bs_done = 0; held = 3'd0;
    build_exp(mode, pl, id);
    got.delete();
    hs_mode = mode; payload = pl; ue_id = id; start = 1'b1; out_ready = 1'b0;
    step;
    start = 1'b0;
    payload = 13'($urandom);
    ue_id = 16'($urandom);
    chk("start_next_state", 32'(fsm_out), (mode == 2'd3) ? 32'd4 : 32'd1);
    while (!seen_done && cyc < 3000) begin
      cyc++;
      if (abort_at >= 0 && beats == abort_at) begin
        chk("abort_pre_state", 32'(fsm_out), 32'd3);
        rst = 1'b1;
        #1;
        chk("abort_idle", 32'(fsm_out), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        step;
        chk("abort_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        step;
        chk("abort_stay_idle", 32'(fsm_out), 32'd0);
        chk("abort_no_done2", 32'(done), 32'd0);
        return;
      end
      if (holding && out_valid) chk("stall_hold", 32'(out_data), 32'(held));
      if (done) begin
        seen_done = 1;
      end else begin
        holding = 0;
        if (out_valid) begin
          if (stall_at >= 0 && beats == stall_at && stall_cnt < 5) begin
            rdy = 0;
            stall_cnt++;
          end else if (rand_rdy) begin
            rdy = 1'($urandom_range(0, 1));
          end else begin
            rdy = 1;
          end
          out_ready = rdy;
          if (rdy) begin
            if (beats < exp_q.size()) chk("sym", 32'(out_data), 32'(exp_q[beats]));
            else chk("extra_beat", 32'(beats), 32'(exp_q.size()));
            got.push_back(out_data);
            beats++;
          end else begin
            holding = 1;
            held = out_data;
          end
        end else begin
          out_ready = 1'b0;
        end
        if (busy_start_at >= 0 && beats == busy_start_at && !bs_done) begin
          start = 1'b1;
          hs_mode = 2'($urandom_range(0, 2));
          bs_done = 1;
        end else begin
          start = 1'b0;
        end
        step;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!seen_done) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("beat_count", 32'(beats), 32'(exp_q.size()));
    chk("finish_state", 32'(fsm_out), 32'd4);
    chk("finish_valid", 32'(out_valid), 32'd0);
    if (finish_start) begin
      start = 1'b1;
      hs_mode = 2'd0;
      payload = 13'($urandom);
    end
    step;
    start = 1'b0;
    chk("post_done_idle", 32'(fsm_out), 32'd0);
    chk("post_done_pulse", 32'(done), 32'd0);
    chk("post_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int nz;
    logic [1:0] m;
    rst = 1'b1; start = 1'b0; hs_mode = 2'd0; payload = 13'd0; ue_id = 16'd0; out_ready = 1'b0;
    repeat (3) step;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fsm", 32'(fsm_out), 32'd0);
    rst = 1'b0;
    step;
    chk("idle_fsm", 32'(fsm_out), 32'd0);

    // All-zero part1 word.
    run_word(2'd0, 13'h0000, 16'($urandom), 0, -1, -1, 0, -1);
    chk("t1_len", 32'(got.size()), 32'd16);
    nz = 0;
    foreach (got[i]) if (got[i] != 3'b000) nz++;
    chk("t1_nonzero", 32'(nz), 32'd0);

    // Impulse response.
    run_word(2'd0, 13'h0080, 16'h1234, 0, -1, -1, 0, -1);
    chk("t2_len", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      chk("t2_sym0", 32'(got[0]), 32'd7);
      chk("t2_sym1", 32'(got[1]), 32'd3);
      chk("t2_sym2", 32'(got[2]), 32'd5);
      nz = 0;
      for (int i = 9; i < 16; i++) if (got[i] != 3'b000) nz++;
      chk("t2_tail_zero", 32'(nz), 32'd0);
    end

    // AGCH with all-ones mask: first CRC symbol sees a lone 1.
    run_word(2'd2, 13'h0000, 16'hFFFF, 0, -1, -1, 0, -1);
    chk("t3_len", 32'(got.size()), 32'd30);
    if (got.size() == 30) chk("t3_beat6", 32'(got[6]), 32'd7);

    // Part2 with a 5-cycle stall in the CRC section.
    run_word(2'd1, 13'h1ABC, 16'($urandom), 0, 20, -1, 0, -1);
    chk("t4_len", 32'(got.size()), 32'd37);

    // Start pulses during PAY and FINISH are ignored; next word starts one cycle after done.
    run_word(2'd1, 13'($urandom), 16'($urandom), 1, -1, 3, 1, -1);
    run_word(2'd2, 13'($urandom), 16'($urandom), 1, -1, -1, 0, -1);

    // Reset in TAIL, then reserved mode, then recovery.
    run_word(2'd0, 13'($urandom), 16'($urandom), 0, -1, -1, 0, 10);
    run_word(2'd3, 13'($urandom), 16'($urandom), 0, -1, -1, 0, -1);
    chk("t6_rsvd_beats", 32'(got.size()), 32'd0);
    run_word(2'd0, 13'($urandom), 16'($urandom), 1, -1, -1, 0, -1);

    for (int r = 0; r < 12; r++) begin
      m = 2'($urandom_range(0, 3));
      run_word(m, 13'($urandom), 16'($urandom), 1, -1, -1, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
